// File: rtl/instr_loader_pkg.sv
// ----------------------------------------------------------------------------
// instr_loader_pkg
// Shared definitions for the instruction loader:
//   LDR_DEPTH_DEFAULT : default instruction memory depth in 32-bit words
//   LDR_NOP_WORD      : word presented to the core when no instruction is valid
//   ldr_state_e       : loader state encoding (LOAD, RUN, OVF)
//   pack_word()       : merges the held lanes with the incoming byte
// ----------------------------------------------------------------------------
package instr_loader_pkg;

    localparam int unsigned LDR_DEPTH_DEFAULT = 64;
    localparam logic [31:0] LDR_NOP_WORD      = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVF  = 2'd2
    } ldr_state_e;

    // Places byte b into lane 'lane' on top of the lanes already held.
    // Lanes above 'lane' come out as zero, which gives the zero padding
    // needed when the program ends part-way through a word.
    function automatic logic [31:0] pack_word(input logic [1:0]  lane,
                                              input logic [23:0] held,
                                              input logic [7:0]  b);
        logic [31:0] w;
        w = 32'h0;
        case (lane)
            2'd0:    w = {24'h0, b};
            2'd1:    w = {16'h0, b, held[7:0]};
            2'd2:    w = {8'h0,  b, held[15:0]};
            default: w = {b, held[23:0]};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instr_mem.sv
// ----------------------------------------------------------------------------
// instr_mem
// Instruction storage: one synchronous write port, one asynchronous read
// port, no reset (contents are undefined until written).
// Ports:
//   clk    : write clock, rising edge
//   we     : write enable
//   waddr  : write word address
//   wdata  : write data
//   raddr  : read word address
//   rdata  : read data, combinational from raddr
// ----------------------------------------------------------------------------
module instr_mem #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_loader.sv
// ----------------------------------------------------------------------------
// instr_loader
// Receives a program as a little-endian byte stream, assembles it into
// 32-bit words in instr_mem, then serves instructions to a single-cycle core
// through a zero-latency read path.
// Ports:
//   clk          : sole clock, rising edge
//   rst          : asynchronous, active-low reset
//   s_valid      : program byte valid
//   s_data       : program byte
//   s_last       : final byte of the program
//   s_ready      : a byte is accepted this cycle (high only in LOAD)
//   reload       : discard the program and restart loading
//   pc_address   : byte address from the core's PC
//   instr        : instruction for the core (NOP_WORD when none is valid)
//   core_run     : registered, high only in RUN
//   word_count   : number of words loaded
//   err_overflow : program exceeded DEPTH words
// ----------------------------------------------------------------------------
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int unsigned DEPTH    = LDR_DEPTH_DEFAULT,
    parameter logic [31:0] NOP_WORD = LDR_NOP_WORD,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    input  logic [7:0]    s_data,
    input  logic          s_last,
    output logic          s_ready,
    input  logic          reload,
    input  logic [31:0]   pc_address,
    output logic [31:0]   instr,
    output logic          core_run,
    output logic [AW:0]   word_count,
    output logic          err_overflow
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    ldr_state_e  state_q, state_d;
    logic [1:0]  lane_q, lane_d;
    logic [23:0] asm_q, asm_d;
    // word_count_q doubles as the write pointer: every written word bumps both.
    logic [AW:0] word_count_q, word_count_d;
    logic        err_q, err_d;
    logic        core_run_q, core_run_d;

    logic        accept;
    logic        full;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [AW-1:0] rd_idx;
    logic        pc_high_set;
    logic        rd_valid;
    logic        unused_pc_bits;

    assign s_ready = (state_q == ST_LOAD);
    assign accept  = s_valid && s_ready;
    assign full    = (word_count_q == FULL_COUNT);

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        asm_d        = asm_q;
        word_count_d = word_count_q;
        err_d        = err_q;
        core_run_d   = core_run_q;
        mem_we       = 1'b0;
        mem_wdata    = pack_word(lane_q, asm_q, s_data);

        if (reload) begin
            // reload wins over any byte offered in the same cycle.
            state_d      = ST_LOAD;
            lane_d       = 2'd0;
            word_count_d = '0;
            err_d        = 1'b0;
            core_run_d   = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (full) begin
                        // Memory filled by a word whose last byte was not
                        // s_last: the program cannot fit, so the following
                        // edge always lands in OVF.
                        state_d    = ST_OVF;
                        err_d      = 1'b1;
                        core_run_d = 1'b0;
                    end else if (accept) begin
                        if (s_last || (lane_q == 2'd3)) begin
                            mem_we       = 1'b1;
                            word_count_d = word_count_q + 1'b1;
                            lane_d       = 2'd0;
                            if (s_last) begin
                                state_d    = ST_RUN;
                                core_run_d = 1'b1;
                            end
                        end else begin
                            asm_d  = mem_wdata[23:0];
                            lane_d = lane_q + 2'd1;
                        end
                    end
                end
                ST_RUN: begin
                    core_run_d = 1'b1;
                end
                ST_OVF: begin
                    core_run_d = 1'b0;
                    err_d      = 1'b1;
                end
                default: begin
                    state_d    = ST_LOAD;
                    lane_d     = 2'd0;
                    core_run_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_LOAD;
            lane_q       <= 2'd0;
            word_count_q <= '0;
            err_q        <= 1'b0;
            core_run_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            word_count_q <= word_count_d;
            err_q        <= err_d;
            core_run_q   <= core_run_d;
        end
    end

    // Assembly lanes are pure data; lane_q alone says which bytes are live.
    always_ff @(posedge clk) begin
        asm_q <= asm_d;
    end

    instr_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (word_count_q[AW-1:0]),
        .wdata (mem_wdata),
        .raddr (rd_idx),
        .rdata (mem_rdata)
    );

    // Byte offset bits of the PC do not select anything.
    assign unused_pc_bits = ^pc_address[1:0];
    assign rd_idx         = pc_address[AW+1:2];
    assign pc_high_set    = |pc_address[31:AW+2];
    assign rd_valid       = (state_q == ST_RUN) && !pc_high_set &&
                            ({1'b0, rd_idx} < word_count_q);
    assign instr          = rd_valid ? mem_rdata : NOP_WORD;

    assign core_run     = core_run_q;
    assign word_count   = word_count_q;
    assign err_overflow = err_q;

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic        s_ready;
    logic        reload;
    logic [31:0] pc_address;
    logic [31:0] instr;
    logic        core_run;
    logic [2:0]  word_count;
    logic        err_overflow;

    int checks;
    int errors;

    typedef struct {
        int          phase;
        logic [31:0] pc;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [17];

    instr_loader #(
        .DEPTH    (DEPTH),
        .NOP_WORD (NOP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .reload       (reload),
        .pc_address   (pc_address),
        .instr        (instr),
        .core_run     (core_run),
        .word_count   (word_count),
        .err_overflow (err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        s_valid = 1'b1;
        s_data  = b;
        s_last  = last;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic do_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    task automatic run_table(input int phase);
        for (int i = 0; i < 17; i++) begin
            if (vecs[i].phase == phase) begin
                pc_address = vecs[i].pc;
                #1;
                check($sformatf("instr_p%0d_pc%0h", phase, vecs[i].pc), instr, vecs[i].exp);
            end
        end
    endtask

    task automatic load_prog_a(input bit stall);
        logic [7:0] prog [8];
        prog = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h80, 8'h10, 8'h00};
        for (int i = 0; i < 8; i++) begin
            if (stall) begin
                int gap;
                gap = $urandom_range(0, 3);
                for (int g = 0; g < gap; g++) begin
                    s_data = 8'hFF;
                    s_last = 1'b1;
                    tick();
                    s_last = 1'b0;
                end
            end
            send_byte(prog[i], i == 7);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vecs[0]  = '{1, 32'h0000_0000, 32'h0010_0013};
        vecs[1]  = '{1, 32'h0000_0004, 32'h0010_8093};
        vecs[2]  = '{1, 32'h0000_0008, NOP};
        vecs[3]  = '{1, 32'h0000_0001, 32'h0010_0013};
        vecs[4]  = '{1, 32'h0000_0007, 32'h0010_8093};
        vecs[5]  = '{1, 32'h0000_0010, NOP};
        vecs[6]  = '{1, 32'h8000_0000, NOP};
        vecs[7]  = '{2, 32'h0000_0004, 32'h0000_00EE};
        vecs[8]  = '{2, 32'h0000_0005, 32'h0000_00EE};
        vecs[9]  = '{2, 32'h0000_0000, 32'hDDCC_BBAA};
        vecs[10] = '{2, 32'h0000_0008, NOP};
        vecs[11] = '{3, 32'h0000_000C, 32'h0F0E_0D0C};
        vecs[12] = '{3, 32'h0000_0000, 32'h0302_0100};
        vecs[13] = '{3, 32'h0000_0010, NOP};
        vecs[14] = '{3, 32'h0000_000E, 32'h0F0E_0D0C};
        vecs[15] = '{4, 32'h0000_0000, 32'h0403_0201};
        vecs[16] = '{4, 32'h0000_0004, NOP};

        rst        = 1'b0;
        s_valid    = 1'b0;
        s_data     = 8'h00;
        s_last     = 1'b0;
        reload     = 1'b0;
        pc_address = 32'h0;

        // Reset state
        #12;
        check("rst_core_run", {31'b0, core_run}, 32'd0);
        check("rst_word_count", {29'b0, word_count}, 32'd0);
        check("rst_err", {31'b0, err_overflow}, 32'd0);
        check("rst_instr", instr, NOP);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        check("rel_s_ready", {31'b0, s_ready}, 32'd1);

        // Two-word program, back to back
        load_prog_a(1'b0);
        check("a_core_run", {31'b0, core_run}, 32'd1);
        check("a_word_count", {29'b0, word_count}, 32'd2);
        check("a_s_ready", {31'b0, s_ready}, 32'd0);
        run_table(1);

        // reload together with an offered byte: reload wins
        pc_address = 32'h0;
        reload  = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h55;
        s_last  = 1'b1;
        tick();
        reload  = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("rl_core_run", {31'b0, core_run}, 32'd0);
        check("rl_s_ready", {31'b0, s_ready}, 32'd1);
        check("rl_word_count", {29'b0, word_count}, 32'd0);
        check("rl_instr", instr, NOP);

        // Partial last word, zero padded
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        send_byte(8'hDD, 1'b0);
        send_byte(8'hEE, 1'b1);
        check("b_word_count", {29'b0, word_count}, 32'd2);
        run_table(2);

        // Same program as the first, with random idle gaps
        do_reload();
        load_prog_a(1'b1);
        check("c_word_count", {29'b0, word_count}, 32'd2);
        check("c_core_run", {31'b0, core_run}, 32'd1);
        run_table(1);

        // Overflow: 17 bytes, no s_last
        do_reload();
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i), 1'b0);
        end
        check("ovf_pre_count", {29'b0, word_count}, 32'd4);
        check("ovf_pre_err", {31'b0, err_overflow}, 32'd0);
        send_byte(8'h10, 1'b0);
        check("ovf_err", {31'b0, err_overflow}, 32'd1);
        check("ovf_s_ready", {31'b0, s_ready}, 32'd0);
        check("ovf_core_run", {31'b0, core_run}, 32'd0);
        pc_address = 32'h0;
        #1;
        check("ovf_instr", instr, NOP);
        tick();
        tick();
        check("ovf_hold_err", {31'b0, err_overflow}, 32'd1);
        check("ovf_hold_s_ready", {31'b0, s_ready}, 32'd0);
        do_reload();
        check("ovf_rl_count", {29'b0, word_count}, 32'd0);
        check("ovf_rl_err", {31'b0, err_overflow}, 32'd0);
        check("ovf_rl_s_ready", {31'b0, s_ready}, 32'd1);

        // Exactly DEPTH words with s_last on the final byte
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i), i == 15);
        end
        check("full_count", {29'b0, word_count}, 32'd4);
        check("full_core_run", {31'b0, core_run}, 32'd1);
        check("full_err", {31'b0, err_overflow}, 32'd0);
        run_table(3);

        // Reset in the middle of a load
        do_reload();
        send_byte(8'h77, 1'b0);
        send_byte(8'h88, 1'b0);
        send_byte(8'h99, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_count", {29'b0, word_count}, 32'd0);
        check("mid_rst_core_run", {31'b0, core_run}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b1);
        check("d_word_count", {29'b0, word_count}, 32'd1);
        check("d_core_run", {31'b0, core_run}, 32'd1);
        run_table(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
